// File: rtl/flag_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flag_cond_pkg
// Purpose  : Shared definitions for the comparator flag consumer: flag bit
//            positions inside the XXXXXGEL word, condition-code encoding and
//            the query FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package flag_cond_pkg;

  // Bit positions of the comparator outcome inside the flag word
  localparam int FLAG_G = 2;
  localparam int FLAG_E = 1;
  localparam int FLAG_L = 0;

  typedef enum logic [2:0] {
    COND_EQ     = 3'd0,
    COND_NE     = 3'd1,
    COND_GT     = 3'd2,
    COND_LT     = 3'd3,
    COND_GE     = 3'd4,
    COND_LE     = 3'd5,
    COND_ALWAYS = 3'd6,
    COND_NEVER  = 3'd7
  } cond_code_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_FLAG = 2'd1,
    S_RESOLVE   = 2'd2,
    S_HOLD      = 2'd3
  } state_e;

  // ALWAYS/NEVER resolve without consulting the flag register
  function automatic logic needs_flags(input logic [2:0] code);
    return !((code == COND_ALWAYS) || (code == COND_NEVER));
  endfunction

endpackage
`default_nettype wire

// File: rtl/flag_cond_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : flag_cond_unit_if
// Purpose  : Handshake bundle between the comparator/sequencer side (master)
//            and the flag condition unit (slave).
// Signals  : flag_valid/flag_in/flag_ready  - flag word channel
//            cond_valid/cond_code/cond_ready - condition query channel
//            res_valid/res_taken/res_ready   - result channel
// Revision : 1.0 - initial release
// ============================================================================
interface flag_cond_unit_if #(
  parameter int FLAG_W = 8
) ();

  logic              flag_valid;
  logic [FLAG_W-1:0] flag_in;
  logic              flag_ready;
  logic              cond_valid;
  logic [2:0]        cond_code;
  logic              cond_ready;
  logic              res_valid;
  logic              res_taken;
  logic              res_ready;

  modport master (
    output flag_valid, flag_in, cond_valid, cond_code, res_ready,
    input  flag_ready, cond_ready, res_valid, res_taken
  );

  modport slave (
    input  flag_valid, flag_in, cond_valid, cond_code, res_ready,
    output flag_ready, cond_ready, res_valid, res_taken
  );

endinterface
`default_nettype wire

// File: rtl/flag_cond_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Purpose  : Purely combinational resolution of a 3-bit condition code
//            against a G/E/L triple. Shared with the branch predictor check.
// Ports    : gel       - {G,E,L} flag bits
//            cond_code - condition selector
//            taken     - condition outcome
// Revision : 1.0 - initial release
// ============================================================================
module cond_eval
  import flag_cond_pkg::*;
(
  input  logic [2:0] gel,
  input  logic [2:0] cond_code,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond_code_e'(cond_code))
      COND_EQ:     taken = gel[FLAG_E];
      COND_NE:     taken = ~gel[FLAG_E];
      COND_GT:     taken = gel[FLAG_G];
      COND_LT:     taken = gel[FLAG_L];
      COND_GE:     taken = gel[FLAG_G] | gel[FLAG_E];
      COND_LE:     taken = gel[FLAG_L] | gel[FLAG_E];
      COND_ALWAYS: taken = 1'b1;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/flag_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_cond_unit
// Purpose  : Holds the latest well-formed comparator flag word and resolves
//            condition queries against it, returning a registered
//            taken/not-taken result.
// Ports    : clk, rst_n  - clock, asynchronous active-low reset
//            bus         - flag / query / result handshakes (slave side)
//            flags_q     - current flag register
//            flags_vld   - flag register loaded since reset
//            err, err_clr- sticky malformed-word flag and its clear
//            taken_cnt   - wrapping count of delivered taken results
// Revision : 1.0 - initial release
// ============================================================================
module flag_cond_unit
  import flag_cond_pkg::*;
#(
  parameter int FLAG_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  flag_cond_unit_if.slave   bus,
  output logic [FLAG_W-1:0] flags_q,
  output logic              flags_vld,
  output logic              err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  taken_cnt
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [FLAG_W-1:0] r_flags;
  logic              r_flags_vld;
  logic              r_err;
  logic [2:0]        r_code;
  logic              r_res_taken;
  logic [CNT_W-1:0]  r_taken_cnt;

  logic w_flag_acc;
  logic w_flag_ok;
  logic w_flag_good;
  logic w_idle_ready;
  logic w_load_code;
  logic w_resolve;
  logic w_release;
  logic w_taken;

  // Flags are always accepted; only the reset window blocks them
  assign bus.flag_ready = rst_n;
  assign w_flag_acc     = bus.flag_valid & bus.flag_ready;
  // Well-formed: reserved bits clear and exactly one of G/E/L set
  assign w_flag_ok      = (bus.flag_in[FLAG_W-1:3] == '0) && $onehot(bus.flag_in[2:0]);
  assign w_flag_good    = w_flag_acc & w_flag_ok;

  assign bus.cond_ready = w_idle_ready & rst_n;
  assign bus.res_valid  = (r_state == S_HOLD);
  assign bus.res_taken  = r_res_taken;
  assign flags_q        = r_flags;
  assign flags_vld      = r_flags_vld;
  assign err            = r_err;
  assign taken_cnt      = r_taken_cnt;

  cond_eval u_cond_eval (
    .gel       (r_flags[2:0]),
    .cond_code (r_code),
    .taken     (w_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idle_ready = 1'b0;
    w_load_code  = 1'b0;
    w_resolve    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle_ready = 1'b1;
        if (bus.cond_valid) begin
          w_load_code = 1'b1;
          // A good flag word landing on the same edge counts as valid flags
          if (!needs_flags(bus.cond_code) || r_flags_vld || w_flag_good) begin
            w_state_nxt = S_RESOLVE;
          end else begin
            w_state_nxt = S_WAIT_FLAG;
          end
        end
      end
      S_WAIT_FLAG: begin
        if (w_flag_good) begin
          w_state_nxt = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        w_resolve   = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags     <= '0;
      r_flags_vld <= 1'b0;
      r_err       <= 1'b0;
      r_code      <= 3'd0;
      r_res_taken <= 1'b0;
      r_taken_cnt <= '0;
    end else begin
      if (w_flag_good) begin
        r_flags     <= bus.flag_in;
        r_flags_vld <= 1'b1;
      end
      // A malformed word outranks a simultaneous clear
      if (w_flag_acc && !w_flag_ok) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
      if (w_load_code) begin
        r_code <= bus.cond_code;
      end
      // Snapshot taken in RESOLVE; stays frozen through HOLD
      if (w_resolve) begin
        r_res_taken <= w_taken;
      end
      if (w_release && r_res_taken) begin
        r_taken_cnt <= r_taken_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Consumer end of the 8-bit comparator flag interface (XXXXXGEL format).
- Accepts comparator flag words over a valid/ready handshake and holds them in a flag register.
- Accepts condition queries on a second handshake, resolves each one against the held flags, and returns a registered taken/not-taken result on a third handshake.
- Sits between the comparator/ALU datapath and the sequencer's branch logic.

Parameters:
- FLAG_W, 8, width of the flag word (bits 2/1/0 = G/E/L, bits 7:3 reserved zero)
- CNT_W, 8, width of the taken-result counter

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- flag_valid  input  1  flag word offered
- flag_in  input  FLAG_W  comparator flag word
- flag_ready  output  1  flag word accepted when high with flag_valid
- cond_valid  input  1  condition query offered
- cond_code  input  3  condition selector
- cond_ready  output  1  query accepted when high with cond_valid
- res_valid  output  1  result available
- res_taken  output  1  condition outcome
- res_ready  input  1  result consumed when high with res_valid
- flags_q  output  FLAG_W  current flag register
- flags_vld  output  1  flag register holds a flag word captured since reset
- err  output  1  sticky malformed-flag indicator
- err_clr  input  1  synchronous clear of err
- taken_cnt  output  CNT_W  count of delivered taken results

Behaviour:
- Reset (async, rst_n=0): all outputs and registers go to 0, including flags_q, flags_vld, err, res_valid, res_taken and taken_cnt. The FSM enters IDLE. Reset mid-query discards the query.
- Flag path:
  - flag_ready is constant 1 outside reset.
  - On a flag accept, the word is well-formed when bits 7:3 are 0 and bits 2:0 are exactly one-hot.
  - Well-formed word: flags_q <= flag_in and flags_vld <= 1.
  - Malformed word: flags_q is unchanged and err <= 1.
  - err_clr clears err. A malformed accept in the same cycle as err_clr wins, so err = 1.
- Condition codes (G/E/L taken from flags_q):
  - 0 EQ = E
  - 1 NE = !E
  - 2 GT = G
  - 3 LT = L
  - 4 GE = G|E
  - 5 LE = L|E
  - 6 ALWAYS = 1
  - 7 NEVER = 0
  - Codes 6 and 7 do not need flags.
- FSM states: IDLE, WAIT_FLAG, RESOLVE, HOLD.
  - IDLE: cond_ready=1. On a cond accept, the code is latched.
    - If code is 6 or 7, or flags_vld is 1 (including flags becoming valid on the same edge), go to RESOLVE.
    - Otherwise go to WAIT_FLAG.
  - WAIT_FLAG: cond_ready=0. Leave for RESOLVE on the first well-formed flag accept. A malformed accept keeps the FSM in WAIT_FLAG.
  - RESOLVE: exactly one cycle. Evaluate the latched code against flags_q, then set res_valid <= 1 and register res_taken. Go to HOLD.
  - HOLD: res_valid=1. res_taken stays stable even if new flags arrive. When res_ready=1, res_valid <= 0, taken_cnt increments if res_taken=1, and the FSM goes to IDLE.
- Latency:
  - Query accept to res_valid is 2 cycles when flags are already valid.
  - When waiting, res_valid rises 2 cycles after the enabling flag accept.
  - Maximum throughput is one query per 3 cycles.
- Flag snapshot:
  - The evaluated flags are the value of flags_q in the RESOLVE cycle.
  - A flag accept coincident with the query accept is therefore seen by the evaluation.
  - A flag accept during the RESOLVE cycle itself is not seen; it applies to the next query.
- Counter: taken_cnt wraps modulo 2^CNT_W, so 255 + 1 = 0 at the default width.
- While in HOLD, res_valid must stay high until res_ready; there is no timeout.

Decomposition:
- Package flag_cond_pkg:
  - Flag bit index constants: FLAG_G=2, FLAG_E=1, FLAG_L=0.
  - Condition code enum: EQ, NE, GT, LT, GE, LE, ALWAYS, NEVER.
  - FSM state enum.
- One combinational sub-module, cond_eval: takes the 3-bit G/E/L value and cond_code and outputs taken. It is reused by the sequencer's branch predictor check.

Test Plan:
1. Flags 8'b00000100 (G) accepted, then query GT with res_ready=1 -> res_taken=1 two cycles after the query accept; taken_cnt=1.
2. Query LE immediately after reset with no flags -> FSM stays in WAIT_FLAG and cond_ready=0. Then flags 8'b00000010 (E) -> res_taken=1 two cycles after the flag accept.
3. Malformed flags 8'b00000110, then 8'b00001001 -> err=1 and flags_q keeps its prior value. err_clr pulse -> err=0. err_clr coincident with a malformed word -> err=1.
4. In HOLD with res_ready=0 for 5 cycles while flags change from E to L -> res_valid and res_taken stay stable. Then res_ready=1 -> res_valid drops, and the next cond_accept becomes possible one cycle later.
5. Flags L plus query EQ on the same edge -> res_taken=0. ALWAYS with flags_vld=0 -> res_taken=1. NEVER -> res_taken=0 and taken_cnt is unchanged.
6. 256 taken results -> taken_cnt wraps to 0. rst_n asserted while in WAIT_FLAG -> all outputs 0 immediately, FSM in IDLE.
